// File: rtl/sp_sr_rx_if.sv
// Serial receiver link bundle: line side inputs (sample strobe, serial pin)
// and byte-consumer side outputs (data, valid/error pulses, busy).
interface sp_sr_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 sampleClk;
   logic                 in;
   logic [DATA_BITS-1:0] out;
   logic                 valid;
   logic                 frameErr;
   logic                 busy;

   modport master (
      output sampleClk, in,
      input  out, valid, frameErr, busy
   );

   modport slave (
      input  sampleClk, in,
      output out, valid, frameErr, busy
   );
endinterface

// File: rtl/sp_sr_rx.sv
// Oversampling serial-to-parallel receiver: start/DATA_BITS MSB-first/stop frames
// on an idle-high line, one-cycle valid or frameErr pulse per frame.
module sp_sr_rx #(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   sp_sr_rx_if.slave   bus
);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   state_t                 r_state;
   logic [TICK_W-1:0]      r_tick;
   logic [BIT_W-1:0]       r_bit;
   logic [DATA_BITS-1:0]   r_shreg;
   logic [DATA_BITS-1:0]   r_out;
   logic                   r_valid;
   logic                   r_ferr;
   logic                   r_busy;

   logic                   w_s;
   state_t                 w_state_nxt;
   logic [TICK_W-1:0]      w_tick_nxt;
   logic [BIT_W-1:0]       w_bit_nxt;
   logic [DATA_BITS-1:0]   w_shreg_nxt;
   logic [DATA_BITS-1:0]   w_out_nxt;
   logic                   w_valid_nxt;
   logic                   w_ferr_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Synchroniser resets to 1s so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every flop updates from pre-edge values.
      if (!reset) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shreg <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_bit   <= w_bit_nxt;
         r_shreg <= w_shreg_nxt;
         r_out   <= w_out_nxt;
         r_valid <= w_valid_nxt;
         r_ferr  <= w_ferr_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no latch is inferred.
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_bit_nxt   = r_bit;
      w_shreg_nxt = r_shreg;
      w_out_nxt   = r_out;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      if (bus.sampleClk) begin
         case (r_state)
            S_IDLE: begin
               if (!w_s) begin
                  w_state_nxt = S_START;
                  w_tick_nxt  = '0;
               end
            end
            S_START: begin
               if (r_tick == TICK_MID) begin
                  w_tick_nxt = '0;
                  if (!w_s) begin
                     w_state_nxt = S_DATA;
                     w_bit_nxt   = '0;
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_DATA: begin
               if (r_tick == TICK_END) begin
                  w_shreg_nxt = {r_shreg[DATA_BITS-2:0], w_s};
                  w_tick_nxt  = '0;
                  if (r_bit == BIT_LAST) w_state_nxt = S_STOP;
                  else                   w_bit_nxt   = r_bit + 1'b1;
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_STOP: begin
               if (r_tick == TICK_END) begin
                  w_tick_nxt = '0;
                  if (w_s) begin
                     w_out_nxt   = r_shreg;
                     w_valid_nxt = 1'b1;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_ferr_nxt  = 1'b1;
                     w_state_nxt = S_WAIT_IDLE;
                  end
               end else begin
                  w_tick_nxt = r_tick + 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               if (w_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign bus.out      = r_out;
   assign bus.valid    = r_valid;
   assign bus.frameErr = r_ferr;
   assign bus.busy     = r_busy;
endmodule

// File: tb/tb_sp_sr_rx.sv
// Scoreboard bench for sp_sr_rx: expected bytes queued at send time and
// popped by a negedge monitor whenever valid pulses.
module tb_sp_sr_rx;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   div = 1;

   int   n_checks = 0;
   int   n_errors = 0;
   int   valid_cnt = 0;
   int   ferr_cnt = 0;
   int   exp_valid = 0;
   int   exp_ferr = 0;
   bit   busy_seen = 1'b0;
   bit   prev_valid = 1'b0;
   logic [7:0] sb[$];

   sp_sr_rx_if #(.DATA_BITS(8)) bus ();

   sp_sr_rx #(
      .DATA_BITS(8),
      .OVERSAMPLE(16),
      .SYNC_STAGES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample strobe: high one clk in every `div` clks.
   initial begin
      int cnt = 0;
      bus.sampleClk = 1'b1;
      forever begin
         @(negedge clk);
         cnt = (cnt + 1 >= div) ? 0 : cnt + 1;
         bus.sampleClk = (cnt == 0);
      end
   end

   always @(negedge clk) begin
      if (bus.busy === 1'b1) busy_seen = 1'b1;
      if (bus.frameErr === 1'b1) ferr_cnt++;
      if (bus.valid === 1'b1) begin
         valid_cnt++;
         check("valid_width", prev_valid, 0);
         check("valid_ferr_excl", bus.frameErr, 0);
         check("sb_underflow", sb.size() == 0, 0);
         if (sb.size() != 0) check("byte", bus.out, sb.pop_front());
      end
      prev_valid = (bus.valid === 1'b1);
   end

   task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
      logic [9:0] f;
      f = {1'b0, d, stop};
      for (int i = 9; i >= 0; i--) begin
         bus.in = f[i];
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic send_good(input logic [7:0] d, input int cpb);
      sb.push_back(d);
      exp_valid++;
      send_frame(d, 1'b1, cpb);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d5a;
      bus.in = 1'b1;

      // T1: reset with strobe every clk
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out", bus.out, 8'h00);
      check("rst_valid", bus.valid, 0);
      check("rst_ferr", bus.frameErr, 0);
      check("rst_busy", bus.busy, 0);
      reset = 1'b1;
      repeat (20) @(negedge clk);

      // T2: single frame
      send_good(8'hA5, 16);
      repeat (20) @(negedge clk);
      wait_drain("drain_a5", 200);
      check("t2_valid_cnt", valid_cnt, exp_valid);
      check("t2_ferr_cnt", ferr_cnt, exp_ferr);

      // T3: back-to-back, no idle gap
      send_good(8'hFF, 16);
      send_good(8'h00, 16);
      repeat (20) @(negedge clk);
      wait_drain("drain_ff00", 200);
      check("t3_valid_cnt", valid_cnt, exp_valid);

      // T4: short glitch rejected as false start
      busy_seen = 1'b0;
      bus.in = 1'b0;
      repeat (6) @(negedge clk);
      bus.in = 1'b1;
      repeat (30) @(negedge clk);
      check("t4_busy_seen", busy_seen, 1);
      check("t4_busy_low", bus.busy, 0);
      check("t4_valid_cnt", valid_cnt, exp_valid);
      check("t4_ferr_cnt", ferr_cnt, exp_ferr);
      check("t4_out_held", bus.out, 8'h00);

      // T5: bad stop bit, line stays low, then recovery
      send_frame(8'h3C, 1'b0, 16);
      exp_ferr++;
      repeat (40) @(negedge clk);
      check("t5_ferr_once", ferr_cnt, exp_ferr);
      check("t5_busy_in_break", bus.busy, 1);
      check("t5_out_held", bus.out, 8'h00);
      check("t5_no_valid", valid_cnt, exp_valid);
      bus.in = 1'b1;
      repeat (8) @(negedge clk);
      check("t5_busy_released", bus.busy, 0);
      repeat (16) @(negedge clk);
      send_good(8'h81, 16);
      repeat (20) @(negedge clk);
      wait_drain("drain_81", 200);
      check("t5_ferr_total", ferr_cnt, exp_ferr);

      // T6: reset during data bit 4 of 0x5A
      d5a = 8'h5A;
      bus.in = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 7; i >= 4; i--) begin
         bus.in = d5a[i];
         repeat (16) @(negedge clk);
      end
      bus.in = d5a[3];
      repeat (8) @(negedge clk);
      check("t6_busy_before_rst", bus.busy, 1);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_rst_out", bus.out, 8'h00);
      check("t6_rst_valid", bus.valid, 0);
      check("t6_rst_ferr", bus.frameErr, 0);
      check("t6_rst_busy", bus.busy, 0);
      bus.in = 1'b1;
      reset = 1'b1;
      repeat (40) @(negedge clk);
      check("t6_no_pulse", valid_cnt, exp_valid);
      send_good(8'hC3, 16);
      repeat (20) @(negedge clk);
      wait_drain("drain_c3", 200);

      // Slower strobe: every 3rd clk, 48 clk per bit
      div = 3;
      repeat (60) @(negedge clk);
      send_good(8'h96, 48);
      repeat (60) @(negedge clk);
      wait_drain("drain_96", 400);
      check("t6_out_96", bus.out, 8'h96);

      check("total_valid", valid_cnt, exp_valid);
      check("total_ferr", ferr_cnt, exp_ferr);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
